// File: rtl/alu_32_pkg.sv
// Shared constants for the 32-bit ALU: data width and the 3-bit opcode map.
package alu_32_pkg;
  localparam int DATA_W = 32;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MULT = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;
endpackage

// File: rtl/alu_32_if.sv
// ALU operand/result bundle. There is no handshake: the master presents
// ALU_OP/A/B/C_I every cycle and R/C_O hold the result of the previous edge.
interface alu_32_if;
  import alu_32_pkg::*;

  logic [2:0]        ALU_OP;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              C_I;
  logic [DATA_W-1:0] R;
  logic              C_O;

  modport master (output ALU_OP, output A, output B, output C_I,
                  input R, input C_O);
  modport slave  (input ALU_OP, input A, input B, input C_I,
                  output R, output C_O);
endinterface

// File: rtl/alu_32_adder.sv
// 32-bit adder with carry-in, carry-out and signed overflow; shared by ADD/SUB/SLT.
module alu_32_adder
  import alu_32_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              c_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              c_o,
  output logic              ovf_o
);
  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, c_i};

  // Overflow: operands share a sign that the sum does not.
  assign ovf_o = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                 (sum_o[DATA_W-1] != a_i[DATA_W-1]);
endmodule

// File: rtl/alu_32.sv
// 32-bit ALU with one-cycle registered result; a new operation every cycle.
module alu_32
  import alu_32_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  alu_32_if.slave   bus
);
  logic [DATA_W-1:0]   add_b;
  logic                add_ci;
  logic [DATA_W-1:0]   add_sum;
  logic                add_co;
  logic                add_ovf;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   r_d, r_q;
  logic                c_d, c_q;

  // SUB and SLT compute A + ~B + 1; only ADD lets C_I through.
  assign add_b  = (bus.ALU_OP == OP_ADD) ? bus.B   : ~bus.B;
  assign add_ci = (bus.ALU_OP == OP_ADD) ? bus.C_I : 1'b1;

  alu_32_adder u_adder (
    .a_i   (bus.A),
    .b_i   (add_b),
    .c_i   (add_ci),
    .sum_o (add_sum),
    .c_o   (add_co),
    .ovf_o (add_ovf)
  );

  assign prod = {{DATA_W{1'b0}}, bus.A} * {{DATA_W{1'b0}}, bus.B};

  always_comb begin
    r_d = '0;
    c_d = 1'b0;
    case (bus.ALU_OP)
      OP_ADD:  begin r_d = add_sum; c_d = add_co; end
      OP_SUB:  begin r_d = add_sum; c_d = add_co; end
      OP_SLT:  r_d = {{(DATA_W-1){1'b0}}, add_sum[DATA_W-1] ^ add_ovf};
      OP_MULT: begin
        r_d = prod[DATA_W-1:0];
        c_d = |prod[2*DATA_W-1:DATA_W];
      end
      OP_XOR:  r_d = bus.A ^ bus.B;
      OP_NOR:  r_d = ~(bus.A | bus.B);
      OP_AND:  r_d = bus.A & bus.B;
      OP_OR:   r_d = bus.A | bus.B;
      default: begin r_d = '0; c_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      c_q <= 1'b0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

  assign bus.R   = r_q;
  assign bus.C_O = c_q;
endmodule

// File: tb/tb_alu_32.sv
// Bench for alu_32: directed vector table, reset sequences, random ops vs a model.
module tb_alu_32;
  import alu_32_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] r;
    logic        co;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs[$];
  logic [32:0] exp_q[$];

  alu_32_if bus ();

  alu_32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic ci);
    logic [63:0] p;
    logic [32:0] s;
    case (op)
      OP_ADD:  s = 33'(a) + 33'(b) + 33'(ci);
      OP_SUB:  s = {(a >= b), a - b};
      OP_SLT:  s = {1'b0, 31'd0, ($signed(a) < $signed(b))};
      OP_MULT: begin
        p = 64'(a) * 64'(b);
        s = {(p[63:32] != 0), p[31:0]};
      end
      OP_XOR:  s = {1'b0, a ^ b};
      OP_NOR:  s = {1'b0, ~(a | b)};
      OP_AND:  s = {1'b0, a & b};
      default: s = {1'b0, a | b};
    endcase
    return s;
  endfunction

  task automatic check(input string name, input logic [32:0] exp);
    total++;
    if ({bus.C_O, bus.R} !== exp) begin
      bad++;
      $display("FAIL %s: got R=%08h C_O=%0b, want R=%08h C_O=%0b",
               name, bus.R, bus.C_O, exp[31:0], exp[32]);
    end
  endtask

  // driver: present inputs, clock one edge, sample #1 later
  task automatic step(input logic r, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic ci);
    rst = r; bus.ALU_OP = op; bus.A = a; bus.B = b; bus.C_I = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic [31:0] r, input logic co);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.ci = ci; v.r = r; v.co = co;
    vecs.push_back(v);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        ci;
    total = 0;
    bad   = 0;
    rst = 1'b1; bus.ALU_OP = OP_ADD; bus.A = 32'd5; bus.B = 32'd9; bus.C_I = 1'b1;

    add_vec(OP_ADD,  32'hC3FF0000, 32'h0000FFFF, 1'b1, 32'hC4000000, 1'b0);
    add_vec(OP_ADD,  32'd5,        32'd9,        1'b0, 32'h0000000E, 1'b0);
    add_vec(OP_ADD,  32'hFFFFFFFF, 32'd0,        1'b1, 32'h00000000, 1'b1);
    add_vec(OP_SUB,  32'd5,        32'hFFFFFFFD, 1'b0, 32'h00000008, 1'b0);
    add_vec(OP_SUB,  32'd5,        32'd4,        1'b1, 32'h00000001, 1'b1);
    add_vec(OP_SUB,  32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b1);
    add_vec(OP_SLT,  32'hFFFFFFFD, 32'hFFFFFFFC, 1'b1, 32'h00000000, 1'b0);
    add_vec(OP_SLT,  32'hFFFFFFFC, 32'hFFFFFFFD, 1'b0, 32'h00000001, 1'b0);
    add_vec(OP_SLT,  32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h00000001, 1'b0);
    add_vec(OP_SLT,  32'h7FFFFFFF, 32'h80000000, 1'b1, 32'h00000000, 1'b0);
    add_vec(OP_XOR,  32'hFFFF0000, 32'h80017FFE, 1'b1, 32'h7FFE7FFE, 1'b0);
    add_vec(OP_NOR,  32'h3FFFFFFC, 32'h00000000, 1'b0, 32'hC0000003, 1'b0);
    add_vec(OP_AND,  32'hFFFFFFFF, 32'h0000FFFF, 1'b1, 32'h0000FFFF, 1'b0);
    add_vec(OP_OR,   32'h1FE0FFFF, 32'h0000FFFF, 1'b0, 32'h1FE0FFFF, 1'b0);
    add_vec(OP_MULT, 32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 1'b1);
    add_vec(OP_MULT, 32'd7,        32'd6,        1'b1, 32'h0000002A, 1'b0);

    // reset state
    step(1'b1, OP_ADD, 32'd5, 32'd9, 1'b1);
    step(1'b1, OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    check("reset", 33'h0);

    // directed table, back-to-back with opcode changes every cycle
    foreach (vecs[i]) begin
      step(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci);
      check($sformatf("vec%0d op%0d", i, vecs[i].op), {vecs[i].co, vecs[i].r});
    end

    // reset for one edge mid-stream discards the op, then normal results resume
    step(1'b0, OP_MULT, 32'd7, 32'd6, 1'b0);
    check("pre_rst", {1'b0, 32'h2A});
    step(1'b1, OP_ADD, 32'd5, 32'd9, 1'b0);
    check("mid_rst", 33'h0);
    step(1'b0, OP_ADD, 32'd5, 32'd9, 1'b0);
    check("post_rst", {1'b0, 32'h0000000E});

    // random ops against the model, including C_I toggling on non-ADD ops
    for (int n = 0; n < 400; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) b = 32'($urandom_range(0, 65535));
      ci = 1'($urandom_range(0, 1));
      exp_q.push_back(model(op, a, b, ci));
      step(1'b0, op, a, b, ci);
      check($sformatf("rand%0d op%0d", n, op), exp_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_32.md
ALU_32 -- requirements
Module: alu_32

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 ALU_OP  input  3  operation select.
REQ-004 A  input  32  operand A.
REQ-005 B  input  32  operand B.
REQ-006 C_I  input  1  carry-in; used by ADD only.
REQ-007 R  output  32  registered result.
REQ-008 C_O  output  1  registered carry/flag out.
REQ-009 No parameters; widths fixed at 32 data bits and 3 opcode bits.

Function
REQ-010 Opcode map SHALL be: 000 ADD, 001 XOR, 010 SUB, 011 MULT, 100 SLT, 101 NOR, 110 AND, 111 OR.
REQ-011 Inputs sampled at each rising clk; R/C_O SHALL present the result of those inputs after that edge (latency 1 cycle, new op accepted every cycle, no handshake).
REQ-012 ADD: {C_O,R} SHALL = A + B + C_I, computed 33 bits wide, unsigned wrap of R.
REQ-013 SUB: {C_O,R} SHALL = A + ~B + 1; C_O = carry out (1 = no borrow, unsigned A >= B); C_I ignored.
REQ-014 SLT: R SHALL = {31'b0, less}, less = signed(A) < signed(B), derived as sign(A-B) XOR signed overflow; C_O = 0.
REQ-015 MULT: R SHALL = low 32 bits of unsigned A*B; C_O = 1 when the high 32 bits of the 64-bit product are nonzero, else 0.
REQ-016 XOR/NOR/AND/OR: R SHALL = bitwise A^B, ~(A|B), A&B, A|B; C_O = 0.
REQ-017 C_I SHALL have no effect for any opcode other than ADD.
REQ-018 Boundaries: ADD 0xFFFFFFFF+0+1 -> R=0, C_O=1; SUB A==B -> R=0, C_O=1; SLT 0x80000000 vs 0x7FFFFFFF -> R=1 (overflow case).
REQ-019 Opcode change between cycles SHALL need no pipeline flush; each edge's result depends only on that edge's inputs.

Reset
REQ-020 While rst=1 at a rising edge, R SHALL load 0x00000000 and C_O SHALL load 0, overriding any op.
REQ-021 Reset asserted mid-stream SHALL discard the op sampled that edge; first valid result appears one edge after the first edge with rst=0.
REQ-022 No other state exists; no asynchronous path from rst.

Structure
REQ-023 Shared package alu_32_pkg SHALL hold the 3-bit opcode constants (OP_ADD..OP_OR) and the data-width constant (32).
REQ-024 One sub-module alu_32_adder (32-bit adder, carry-in, carry-out, overflow) SHALL be shared by ADD, SUB and SLT; multiplier, logic ops and output register live in alu_32.

Verification
REQ-025 ADD A=0xC3FF0000, B=0x0000FFFF, C_I=1 -> R=0xC4000000, C_O=0; ADD 5+9, C_I=0 -> R=0x0000000E, C_O=0.
REQ-026 SUB A=5, B=0xFFFFFFFD (-3) -> R=0x00000008, C_O=0; SUB 5-4 -> R=0x00000001, C_O=1.
REQ-027 SLT A=-3, B=-4 -> R=0; A=-4, B=-3 -> R=1; C_O=0 both.
REQ-028 Logic: XOR 0xFFFF0000,0x80017FFE -> 0x7FFE7FFE; NOR 0x3FFFFFFC,0 -> 0xC0000003; AND 0xFFFFFFFF,0x0000FFFF -> 0x0000FFFF; OR 0x1FE0FFFF,0x0000FFFF -> 0x1FE0FFFF; C_O=0.
REQ-029 MULT 0x00010000*0x00010000 -> R=0, C_O=1; MULT 7*6 -> R=0x0000002A, C_O=0.
REQ-030 Reset: rst=1 for one edge during ADD 5+9 -> R=0, C_O=0 after that edge; rst=0 next edge -> R=0x0000000E.
